// File: rtl/lsu_bank_arbiter_if.sv
// lsu_bank_arbiter_if -- bundle between four LSUs, the bank arbiter and one
// SRAM bank.
//   req_*  : per-LSU request lanes, packed lane i at [i*W +: W]
//   rsp_*  : one-hot load-data strobe plus shared load data
//   mem_*  : single-port bank access; mem_rdata valid one cycle after a read
// modport slave  : the arbiter
// modport master : its environment (the LSUs and the SRAM bank together)
interface lsu_bank_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [3:0]          req_valid;
  logic [3:0]          req_we;
  logic [3:0]          req_lock;
  logic [4*ADDR_W-1:0] req_addr;
  logic [4*DATA_W-1:0] req_wdata;
  logic [3:0]          req_ready;
  logic [3:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                mem_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;

  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_lock, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_bank_arbiter.sv
// lsu_bank_arbiter -- zero-wait round-robin arbiter of four LSUs onto one
// SRAM bank, with burst locking and a one-deep load response pipe.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : lsu_bank_arbiter_if.slave (requests, grants, responses, bank port)
// Grant and bank outputs are combinational from state and requests; the
// response strobe is registered one cycle behind a load grant.
module lsu_bank_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  lsu_bank_arbiter_if.slave   bus
);
  localparam int NUM_LANES = 4;

  typedef enum logic {ARB, BURST} state_e;

  state_e         state_q, state_d;
  logic [1:0]     ptr_q, ptr_d;
  logic [1:0]     owner_q, owner_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [NUM_LANES-1:0] rsp_gnt_q, rsp_gnt_d;
  logic           rd_q, rd_d;

  logic [NUM_LANES-1:0] gnt;
  logic [1:0]     gnt_idx;
  logic [1:0]     idx;
  logic           found;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // Grant selection: rotating search from ptr in ARB, owner-only in BURST.
  always_comb begin
    gnt     = '0;
    gnt_idx = ptr_q;
    idx     = '0;
    found   = 1'b0;
    if (state_q == ARB) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        idx = ptr_q + 2'(k);
        if (!found && bus.req_valid[idx]) begin
          found   = 1'b1;
          gnt_idx = idx;
        end
      end
    end else begin
      gnt_idx = owner_q;
      found   = bus.req_valid[owner_q];
    end
    if (found) gnt[gnt_idx] = 1'b1;
    // Outputs stay quiet while reset is held, regardless of clk.
    if (rst) gnt = '0;
  end

  // Bank mux: grant is one-hot, so an AND-OR over lanes selects the winner
  // and yields zero when nothing is granted.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (gnt[i]) begin
        mem_addr  = mem_addr  | bus.req_addr [i*ADDR_W +: ADDR_W];
        mem_wdata = mem_wdata | bus.req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.req_ready = gnt;
  assign bus.mem_en    = |gnt;
  assign bus.mem_we    = |(gnt & bus.req_we);
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

  // Load response follows the grant by exactly one cycle; data is masked so
  // the shared bus reads zero when no strobe is up.
  assign bus.rsp_valid = rd_q ? rsp_gnt_q     : '0;
  assign bus.rsp_rdata = rd_q ? bus.mem_rdata : '0;

  // Next-state for the ARB/BURST controller.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    rsp_gnt_d = gnt;
    rd_d      = (|gnt) && !(|(gnt & bus.req_we));
    case (state_q)
      ARB: begin
        if (|gnt) begin
          ptr_d = gnt_idx + 2'd1;
          if (bus.req_lock[gnt_idx] && (MAX_BURST > 1)) begin
            state_d = BURST;
            owner_d = gnt_idx;
            cnt_d   = 4'd1;
          end
        end
      end
      BURST: begin
        if (gnt == '0) begin
          // Owner went idle: give up this cycle, re-arbitrate next cycle.
          state_d = ARB;
          ptr_d   = owner_q + 2'd1;
        end else begin
          cnt_d = cnt_q + 4'd1;
          // A grant with lock dropped is still honoured as the final beat.
          if (!bus.req_lock[owner_q] || (cnt_d == 4'(MAX_BURST))) begin
            state_d = ARB;
            ptr_d   = owner_q + 2'd1;
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB;
      ptr_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      rsp_gnt_q <= '0;
      rd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      rsp_gnt_q <= rsp_gnt_d;
      rd_q      <= rd_d;
    end
  end
endmodule

// File: tb/tb_lsu_bank_arbiter.sv
// tb_lsu_bank_arbiter -- directed scenarios plus randomized traffic against
// a behavioural model (round-robin pointer, burst owner/length, pending load
// and a reference copy of bank contents). A small SRAM model answers the
// bank port and returns junk when no read was issued.
module tb_lsu_bank_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_bank_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  lsu_bank_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- SRAM bank model ----------------
  logic [DW-1:0] sram [0:(1<<AW)-1];
  bit sram_init = 0;
  always @(posedge clk) begin
    if (!sram_init) begin
      for (int i = 0; i < (1<<AW); i++) sram[i] = 32'hC0DE_0000 + i;
      sram_init = 1;
    end
    if (bus.mem_en && bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= sram[bus.mem_addr];
    else                           bus.mem_rdata <= $urandom;
  end

  // ---------------- behavioural model + compare ----------------
  int            m_ptr = 0, m_owner = 0, m_len = 0;
  bit            m_burst = 0;
  bit            p_v = 0;
  int            p_lsu = 0;
  logic [DW-1:0] p_data = '0;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  bit            ref_init = 0;
  logic [3:0]    m_exp_ready = '0;

  always @(negedge clk) begin : cmp
    int g;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    if (!ref_init) begin
      for (int i = 0; i < (1<<AW); i++) ref_mem[i] = 32'hC0DE_0000 + i;
      ref_init = 1;
    end
    if (rst) begin
      chk("rst.ready", bus.req_ready, 0);
      chk("rst.mem_en", bus.mem_en, 0);
      chk("rst.mem_we", bus.mem_we, 0);
      chk("rst.mem_addr", bus.mem_addr, 0);
      chk("rst.mem_wdata", bus.mem_wdata, 0);
      chk("rst.rsp_valid", bus.rsp_valid, 0);
      chk("rst.rsp_rdata", bus.rsp_rdata, 0);
      m_ptr = 0; m_owner = 0; m_len = 0; m_burst = 0; p_v = 0;
      m_exp_ready = '0;
    end else begin
      g = -1;
      if (m_burst) begin
        if (bus.req_valid[m_owner]) g = m_owner;
      end else begin
        for (int k = 0; k < 4; k++)
          if (g < 0 && bus.req_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      end
      a = (g >= 0) ? bus.req_addr[g*AW +: AW]  : '0;
      d = (g >= 0) ? bus.req_wdata[g*DW +: DW] : '0;
      m_exp_ready = (g >= 0) ? 4'(1 << g) : 4'd0;
      chk("ready", bus.req_ready, m_exp_ready);
      chk("mem_en", bus.mem_en, g >= 0);
      chk("mem_we", bus.mem_we, (g >= 0) ? bus.req_we[g] : 1'b0);
      chk("mem_addr", bus.mem_addr, a);
      chk("mem_wdata", bus.mem_wdata, d);
      chk("rsp_valid", bus.rsp_valid, p_v ? 4'(1 << p_lsu) : 4'd0);
      chk("rsp_rdata", bus.rsp_rdata, p_v ? p_data : '0);
      // advance: bank contents in grant order, then arbitration state
      p_v = (g >= 0) && !bus.req_we[g];
      if (p_v) begin p_lsu = g; p_data = ref_mem[a]; end
      if (g >= 0 && bus.req_we[g]) ref_mem[a] = d;
      if (m_burst) begin
        if (g < 0) begin
          m_burst = 0; m_ptr = (m_owner + 1) % 4;
        end else begin
          m_len++;
          if (!bus.req_lock[m_owner] || m_len == MB) begin
            m_burst = 0; m_ptr = (m_owner + 1) % 4;
          end
        end
      end else if (g >= 0) begin
        m_ptr = (g + 1) % 4;
        if (bus.req_lock[g] && MB > 1) begin
          m_burst = 1; m_owner = g; m_len = 1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] we,
                       input logic [3:0] lk, input logic [4*AW-1:0] a,
                       input logic [4*DW-1:0] d);
    @(posedge clk); #1;
    rst = r;
    bus.req_valid = v; bus.req_we = we; bus.req_lock = lk;
    bus.req_addr = a; bus.req_wdata = d;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic idle();
    drive(0, 4'b0, 4'b0, 4'b0, '0, '0);
  endtask

  logic [3:0] exp_a [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] exp_c [6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0001};
  logic [3:0] v_d   [4] = '{4'b1111, 4'b1111, 4'b1101, 4'b1101};
  logic [3:0] exp_d [4] = '{4'b0010, 4'b0010, 4'b0000, 4'b0100};

  initial begin
    logic [3:0] v, we, lk;
    logic [4*AW-1:0] ra;
    logic [4*DW-1:0] rd;
    logic r;
    rst = 1'b1;
    bus.req_valid = '0; bus.req_we = '0; bus.req_lock = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) @(posedge clk);

    // All four LSUs load continuously straight out of reset.
    for (int i = 0; i < 5; i++) begin
      drive(0, 4'b1111, 4'b0, 4'b0, {10'h13, 10'h12, 10'h11, 10'h10}, '0);
      settle();
      chk("A.ready", bus.req_ready, exp_a[i]);
      chk("A.model", m_exp_ready, exp_a[i]);
      if (i > 0) chk("A.rsp_valid", bus.rsp_valid, exp_a[i-1]);
      if (i == 1) chk("A.rsp_rdata", bus.rsp_rdata, 32'hC0DE_0010);
    end
    idle(); settle();
    chk("A.rsp_last", bus.rsp_valid, 4'b0001);

    // LSU2 store alone.
    drive(0, 4'b0100, 4'b0100, 4'b0, {10'h0, 10'h3A, 20'h0}, {32'h0, 32'hDEADBEEF, 64'h0});
    settle();
    chk("B.ready", bus.req_ready, 4'b0100);
    chk("B.mem_en", bus.mem_en, 1);
    chk("B.mem_we", bus.mem_we, 1);
    chk("B.mem_addr", bus.mem_addr, 10'h3A);
    chk("B.mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    idle(); settle();
    chk("B.no_rsp", bus.rsp_valid, 0);

    // ptr=3, only LSU0 requests (load of the stored word).
    drive(0, 4'b0001, 4'b0, 4'b0, {30'h0, 10'h3A}, '0);
    settle();
    chk("W.ready", bus.req_ready, 4'b0001);
    drive(0, 4'b0111, 4'b0, 4'b0, {30'h0, 10'h3A}, '0);
    settle();
    chk("W.ptr1", bus.req_ready, 4'b0010);
    chk("W.rsp_valid", bus.rsp_valid, 4'b0001);
    chk("W.rsp_rdata", bus.rsp_rdata, 32'hDEADBEEF);
    idle();

    // ptr=2 -> lone LSU0 grant moves ptr to 1, then LSU1 bursts to MAX_BURST.
    drive(0, 4'b0001, 4'b0, 4'b0, '0, '0);
    settle();
    chk("C.pre", bus.req_ready, 4'b0001);
    for (int i = 0; i < 6; i++) begin
      drive(0, 4'b1011, 4'b0, 4'b0010, '0, '0);
      settle();
      chk("C.ready", bus.req_ready, exp_c[i]);
      chk("C.model", m_exp_ready, exp_c[i]);
    end
    idle();

    // ptr=1: LSU1 burst drops valid after two grants.
    for (int i = 0; i < 4; i++) begin
      drive(0, v_d[i], 4'b0, 4'b0010, '0, '0);
      settle();
      chk("D.ready", bus.req_ready, exp_d[i]);
    end
    idle();

    // ptr=3: LSU3 load, then reset in the following cycle.
    drive(0, 4'b1000, 4'b0, 4'b0, '0, '0);
    settle();
    chk("E.ready", bus.req_ready, 4'b1000);
    drive(1, 4'b1111, 4'b0, 4'b0, '0, '0);
    settle();
    chk("E.rsp_killed", bus.rsp_valid, 0);
    chk("E.ready_rst", bus.req_ready, 0);
    drive(1, 4'b1111, 4'b0, 4'b0, '0, '0);
    drive(0, 4'b1110, 4'b0, 4'b0, '0, '0);
    settle();
    chk("E.first", bus.req_ready, 4'b0010);
    chk("E.no_stale", bus.rsp_valid, 0);
    idle(); settle();
    chk("E.rsp", bus.rsp_valid, 4'b0010);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 299) == 0);
      v  = 4'($urandom | $urandom);
      we = 4'($urandom);
      lk = 4'($urandom | $urandom);
      for (int i = 0; i < 4; i++) begin
        ra[i*AW +: AW] = AW'($urandom_range(0, 7));
        rd[i*DW +: DW] = $urandom;
      end
      drive(r, v, we, lk, ra, rd);
    end
    idle(); settle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/lsu_bank_arbiter.md
LSU_BANK_ARBITER -- requirements
Module: lsu_bank_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, SRAM bank word-address width.
REQ-002 Parameter DATA_W, default 32, data width; matches the LSU datapath width.
REQ-003 Parameter MAX_BURST, default 4, maximum consecutive grants to one locked requester; legal range 1..15.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  4  per-LSU access request, index 0..3.
REQ-007 req_we  input  4  per-LSU write enable; 1 = store, 0 = load.
REQ-008 req_lock  input  4  per-LSU burst-lock request.
REQ-009 req_addr  input  4*ADDR_W  per-LSU address; LSU i occupies bits [i*ADDR_W +: ADDR_W].
REQ-010 req_wdata  input  4*DATA_W  per-LSU store data, packed the same way as req_addr.
REQ-011 req_ready  output  4  one-hot grant; the access completes when req_valid[i] and req_ready[i] are both high.
REQ-012 rsp_valid  output  4  one-hot load-data-valid strobe.
REQ-013 rsp_rdata  output  DATA_W  load data shared by all LSUs; qualified by rsp_valid.
REQ-014 mem_en, mem_we  output  1 each  bank enable and bank write enable.
REQ-015 mem_addr, mem_wdata  output  ADDR_W, DATA_W  bank address and write data.
REQ-016 mem_rdata  input  DATA_W  bank read data, valid one cycle after a read enable.

Function
REQ-017 At most one req_ready bit shall be high per cycle, and only for a requester whose req_valid is high.
REQ-018 req_ready, mem_en, mem_we, mem_addr and mem_wdata shall be combinational from the current state and the requests; the grant is zero-wait.
REQ-019 mem_en shall equal OR(req_ready); mem_we, mem_addr and mem_wdata shall come from the granted requester; they shall be 0 when there is no grant.
REQ-020 FSM states: ARB and BURST.
REQ-021 In ARB, the arbiter shall grant round-robin, starting the search at index ptr.
REQ-022 After a grant to LSU g, ptr shall become (g+1) mod 4, wrapping from 3 to 0.
REQ-023 With no request pending, ptr shall hold.
REQ-024 Entering BURST: a grant in ARB to LSU g with req_lock[g]=1 and MAX_BURST>1 shall store owner=g and burst_cnt=1, and move to BURST.
REQ-025 In BURST, only the owner shall be granted, even if other LSUs are requesting.
REQ-026 Each burst grant shall increment burst_cnt.
REQ-027 Leaving BURST: the FSM shall return to ARB with ptr=(owner+1) mod 4 on whichever comes first: req_lock[owner] low, burst_cnt reaching MAX_BURST, or a cycle with req_valid[owner] low.
REQ-028 When BURST exits because req_valid[owner] is low, that cycle shall produce no grant; re-arbitration happens next cycle.
REQ-029 When BURST exits because req_lock[owner] is low, that cycle's grant shall still go to the owner if it is requesting, and it shall be the last grant of the burst.
REQ-030 Read response: for a granted load, rsp_valid shall be one-hot for that LSU exactly one cycle after the grant, with rsp_rdata=mem_rdata.
REQ-031 rsp_rdata shall be 0 whenever rsp_valid is 0.
REQ-032 Loads shall pipeline back-to-back: one response per cycle, returned in grant order.
REQ-033 Stores shall produce no rsp_valid.
REQ-034 A load and a store to the same address in consecutive cycles shall be issued to the bank in grant order; the arbiter does no data forwarding.
REQ-035 There is no response backpressure; requesters shall accept rsp_valid unconditionally.

Reset
REQ-036 On rst high, asynchronously and independent of clk: state=ARB, ptr=0, owner=0, burst_cnt=0, rsp_valid=0, and the registered grant and read flag shall be 0.
REQ-037 During reset, req_ready and every mem_* output shall be forced to 0.
REQ-038 Reset asserted mid-burst or with a load in flight shall discard that burst or load; no rsp_valid shall follow after reset is released.
REQ-039 After rst falls, the first grant shall be available in the first clock cycle.

Verification
REQ-040 All four LSUs load continuously from reset -> req_ready sequence 0001,0010,0100,1000,0001; each rsp_valid follows its grant by 1 cycle with mem_rdata.
REQ-041 LSU2 stores alone, addr 0x3A, data 0xDEADBEEF -> mem_en=1, mem_we=1, mem_addr=0x3A, mem_wdata=0xDEADBEEF in the same cycle; no rsp_valid.
REQ-042 MAX_BURST=4; LSU1 locked and valid for 6 cycles, LSU0 and LSU3 also valid -> LSU1 granted 4 consecutive cycles, then LSU3, then LSU0.
REQ-043 LSU1 in burst drops req_valid after 2 grants, others valid -> 1 idle cycle, then LSU2 granted.
REQ-044 rst pulsed in the cycle after a load grant -> no rsp_valid; after release the first grant goes to the lowest-index requester (ptr=0).
REQ-045 Ptr wrap: ptr=3 and only LSU0 requesting -> LSU0 granted the same cycle; ptr becomes 1.
